// File: rtl/combination_lock_param_fsm.sv
// Rotary combination lock: N digits entered with alternating turn
// directions, Center to open, failed-attempt counter with timed lockout.
// Ports: Clk, South (async reset), Right/Left (turn levels), Count (dial
//   position), Center (raw button) -> state, Locked, Lockout, FailCount.
module combination_lock_param_fsm #(
  parameter int NUM_DIGITS = 3,
  parameter int POS_W = 5,
  parameter logic [NUM_DIGITS*POS_W-1:0] COMBO = 15'h34F5,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int STATE_W = $clog2(NUM_DIGITS+4),
  localparam int FAIL_W = $clog2(MAX_FAILS+1),
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES+1)
) (
  input  logic               Clk,
  input  logic               South,
  input  logic               Right,
  input  logic               Left,
  input  logic [POS_W-1:0]   Count,
  input  logic               Center,
  output logic [STATE_W-1:0] state,
  output logic               Locked,
  output logic               Lockout,
  output logic [FAIL_W-1:0]  FailCount
);

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = state_t'(0);
  localparam state_t S_OPEN = state_t'(NUM_DIGITS+1);
  localparam state_t S_FAIL = state_t'(NUM_DIGITS+2);
  localparam state_t S_LOCK = state_t'(NUM_DIGITS+3);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES-1);

  state_t            state_q;
  state_t            state_n;
  logic [FAIL_W-1:0] fail_q;
  logic [FAIL_W-1:0] fail_n;
  logic [TMR_W-1:0]  tmr_q;
  logic [TMR_W-1:0]  tmr_n;
  logic              center_q;

  logic              cen_rise;
  logic              rgt;
  logic              lft;
  logic              opp;
  logic              hit;
  logic              in_dig;
  logic              even;
  logic              last;
  logic              go_fail;
  logic [POS_W-1:0]  digit;

  assign cen_rise = Center & ~center_q;
  // Both directions at once is a decoder glitch: treat as no turn.
  assign rgt = Right & ~Left;
  assign lft = Left & ~Right;

  always_ff @(posedge Clk or posedge South) begin
    if (South) begin
      state_q  <= S_IDLE;
      fail_q   <= '0;
      tmr_q    <= '0;
      center_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      fail_q   <= fail_n;
      tmr_q    <= tmr_n;
      center_q <= Center;
    end
  end

  always_comb begin
    state_n = state_q;
    fail_n  = fail_q;
    tmr_n   = tmr_q;
    go_fail = 1'b0;
    in_dig  = 1'b0;
    even    = 1'b0;
    last    = 1'b0;
    digit   = '0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state_q == state_t'(i+1)) begin
        in_dig = 1'b1;
        even   = (i % 2) == 0;
        last   = (i == NUM_DIGITS-1);
        digit  = COMBO[POS_W*i +: POS_W];
      end
    end

    // Digit i is dialled turning Right (even) / Left (odd); the
    // opposite turn commits it.
    opp = even ? lft : rgt;
    hit = (Count == digit);

    case (state_q)
      S_IDLE: begin
        if (rgt) state_n = S_IDLE + state_t'(1);
      end
      S_OPEN: begin
        if (cen_rise) state_n = S_IDLE;
      end
      S_FAIL: begin
        if (fail_q == FAIL_MAX) begin
          state_n = S_LOCK;
          tmr_n   = TMR_LOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOCK: begin
        if (tmr_q == '0) begin
          state_n = S_IDLE;
          fail_n  = '0;
        end else begin
          tmr_n = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        if (!in_dig) begin
          state_n = S_IDLE;
        end else if (last) begin
          if (cen_rise) begin
            if (hit) begin
              state_n = S_OPEN;
              fail_n  = '0;
            end else begin
              go_fail = 1'b1;
            end
          end else if (opp) begin
            go_fail = 1'b1;
          end
        end else if (opp) begin
          if (hit) state_n = state_q + state_t'(1);
          else go_fail = 1'b1;
        end else if (cen_rise) begin
          go_fail = 1'b1;
        end
      end
    endcase

    if (go_fail) begin
      state_n = S_FAIL;
      if (fail_q != FAIL_MAX) fail_n = fail_q + FAIL_W'(1);
    end
  end

  assign state     = state_q;
  assign Locked    = (state_q != S_OPEN);
  assign Lockout   = (state_q == S_LOCK);
  assign FailCount = fail_q;

endmodule

// File: tb/tb_combination_lock_param_fsm.sv
// Directed bench for combination_lock_param_fsm with default parameters.
// Combination 21/7/13; states IDLE=0 DIG=1..3 OPEN=4 FAIL=5 LOCKOUT=6.
module tb_combination_lock_param_fsm;

  logic       Clk = 1'b0;
  logic       South = 1'b1;
  logic       Right = 1'b0;
  logic       Left = 1'b0;
  logic [4:0] Count = '0;
  logic       Center = 1'b0;
  logic [2:0] state;
  logic       Locked;
  logic       Lockout;
  logic [1:0] FailCount;

  int n_chk = 0;
  int n_fail = 0;

  combination_lock_param_fsm dut (
    .Clk(Clk), .South(South), .Right(Right), .Left(Left),
    .Count(Count), .Center(Center), .state(state),
    .Locked(Locked), .Lockout(Lockout), .FailCount(FailCount)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l,
                       input logic [4:0] c, input logic cen);
    Right = r;
    Left = l;
    Count = c;
    Center = cen;
  endtask

  task automatic pulse_reset();
    #1 South = 1'b1;
    #1 South = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d want 0", state);
    end
    n_chk++;
    if (Locked !== 1'b1 || Lockout !== 1'b0 || FailCount !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outs got L=%b LO=%b FC=%0d want 1 0 0",
               Locked, Lockout, FailCount);
    end
    step();
    South = 1'b0;
  endtask

  task automatic test_unlock();
    logic [2:0] exp_st [4];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1, 0, 5'd0, 0);
        1: drive(0, 1, 5'd21, 0);
        2: drive(1, 0, 5'd7, 0);
        default: drive(0, 0, 5'd13, 1);
      endcase
      if (k == 3) begin
        n_chk++;
        if (Locked !== 1'b1) begin
          n_fail++;
          $display("FAIL unlock_pre_edge Locked got %b want 1", Locked);
        end
      end
      step();
      n_chk++;
      if (state !== exp_st[k]) begin
        n_fail++;
        $display("FAIL unlock_seq_%0d state got %0d want %0d",
                 k, state, exp_st[k]);
      end
    end
    n_chk++;
    if (Locked !== 1'b0 || FailCount !== 2'd0) begin
      n_fail++;
      $display("FAIL unlock_open got L=%b FC=%0d want 0 0",
               Locked, FailCount);
    end
    drive(0, 0, 5'd0, 0);
    step();
    drive(0, 0, 5'd0, 1);
    step();
    n_chk++;
    if (state !== 3'd0 || Locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock got st=%0d L=%b want 0 1", state, Locked);
    end
    drive(0, 0, 5'd0, 0);
    step();
  endtask

  task automatic test_wrong_digit();
    drive(1, 0, 5'd0, 0);
    step();
    drive(0, 1, 5'd20, 0);
    step();
    n_chk++;
    if (state !== 3'd5 || FailCount !== 2'd1 || Locked !== 1'b1) begin
      n_fail++;
      $display("FAIL wrong_digit got st=%0d FC=%0d L=%b want 5 1 1",
               state, FailCount, Locked);
    end
    drive(0, 0, 5'd0, 0);
    step();
    n_chk++;
    if (state !== 3'd0 || FailCount !== 2'd1) begin
      n_fail++;
      $display("FAIL fail_to_idle got st=%0d FC=%0d want 0 1",
               state, FailCount);
    end
  endtask

  task automatic test_lockout();
    pulse_reset();
    for (int a = 0; a < 3; a++) begin
      drive(1, 0, 5'd0, 0);
      step();
      drive(0, 1, 5'd3, 0);
      step();
      drive(0, 0, 5'd0, 0);
      if (a < 2) step();
    end
    n_chk++;
    if (state !== 3'd5 || FailCount !== 2'd3) begin
      n_fail++;
      $display("FAIL third_fail got st=%0d FC=%0d want 5 3",
               state, FailCount);
    end
    step();
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (state !== 3'd6 || Lockout !== 1'b1) begin
        n_fail++;
        $display("FAIL lockout_cyc_%0d got st=%0d LO=%b want 6 1",
                 k, state, Lockout);
      end
      case (k)
        0: drive(1, 0, 5'd0, 0);
        1: drive(0, 1, 5'd21, 0);
        2: drive(1, 0, 5'd7, 0);
        3: drive(0, 0, 5'd13, 1);
        default: drive(0, 0, 5'd0, 0);
      endcase
      step();
    end
    n_chk++;
    if (state !== 3'd0 || Lockout !== 1'b0 || FailCount !== 2'd0) begin
      n_fail++;
      $display("FAIL lockout_end got st=%0d LO=%b FC=%0d want 0 0 0",
               state, Lockout, FailCount);
    end
  endtask

  task automatic test_center_hold();
    drive(1, 0, 5'd0, 0);
    step();
    drive(0, 1, 5'd21, 0);
    step();
    drive(1, 0, 5'd7, 0);
    step();
    drive(0, 0, 5'd13, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if (state !== 3'd4) begin
        n_fail++;
        $display("FAIL center_hold_%0d state got %0d want 4", k, state);
      end
    end
    drive(0, 0, 5'd0, 0);
    step();
    drive(0, 0, 5'd0, 1);
    step();
    n_chk++;
    if (state !== 3'd0 || Locked !== 1'b1) begin
      n_fail++;
      $display("FAIL repress_relock got st=%0d L=%b want 0 1",
               state, Locked);
    end
    drive(0, 0, 5'd0, 0);
    step();
  endtask

  task automatic test_both_dirs();
    drive(1, 0, 5'd0, 0);
    step();
    drive(0, 1, 5'd21, 0);
    step();
    drive(1, 1, 5'd7, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (state !== 3'd2) begin
        n_fail++;
        $display("FAIL both_dirs_%0d state got %0d want 2", k, state);
      end
    end
    drive(0, 0, 5'd7, 1);
    step();
    n_chk++;
    if (state !== 3'd5 || FailCount !== 2'd1) begin
      n_fail++;
      $display("FAIL premature_center got st=%0d FC=%0d want 5 1",
               state, FailCount);
    end
    drive(0, 0, 5'd0, 0);
    step();
  endtask

  task automatic test_async_reset();
    drive(1, 0, 5'd0, 0);
    step();
    drive(0, 1, 5'd21, 0);
    step();
    drive(0, 0, 5'd0, 0);
    n_chk++;
    if (state !== 3'd2 || FailCount !== 2'd1) begin
      n_fail++;
      $display("FAIL pre_reset got st=%0d FC=%0d want 2 1",
               state, FailCount);
    end
    #2 South = 1'b1;
    #1;
    n_chk++;
    if (state !== 3'd0 || Locked !== 1'b1 || FailCount !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset got st=%0d L=%b FC=%0d want 0 1 0",
               state, Locked, FailCount);
    end
    #1 South = 1'b0;
    drive(1, 0, 5'd0, 0);
    step();
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL post_reset_right state got %0d want 1", state);
    end
    drive(0, 0, 5'd0, 0);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_digit();
    test_lockout();
    test_center_hold();
    test_both_dirs();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
